// File: rtl/window_buffer5x5_pkg.sv
// Shared constants for the 5x5 window generator.
// The window is stored row-major, so element k = r*WIN_DIM + c.
package window_buffer5x5_pkg;
    localparam int WIN_DIM   = 5;
    localparam int WIN_ELEMS = WIN_DIM * WIN_DIM;
    localparam int NUM_LB    = WIN_DIM - 1;
    localparam int CTR_MIN   = WIN_DIM - 1;   // first row/col index that completes a window
    localparam int CTR_OFS   = WIN_DIM / 2;   // distance from newest pixel to window centre
endpackage

// File: rtl/window_buffer5x5_line_buffer.sv
// Enable-gated delay line of DEPTH accepted pixels: circular RAM, read-before-write.
// Storage is deliberately unreset so it can map onto RAM; only the pointer resets.
module window_buffer5x5_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (en_i) mem[ptr_q] <= din_i;
    end

    // Slot about to be overwritten holds the pixel accepted DEPTH enables ago.
    assign dout_o = mem[ptr_q];
endmodule

// File: rtl/window_buffer5x5.sv
// Raster-stream 5x5 window generator: four cascaded line buffers feed a shifting
// window register array; only fully-interior windows are flagged valid.
import window_buffer5x5_pkg::*;

module window_buffer5x5 #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64,
    parameter int WINDOW_S    = 25,
    parameter int WINDOW_BITS = WINDOW_S * DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [WINDOW_BITS-1:0]        pack_wBuffer
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);

    logic [NUM_LB-1:0][DATA_WIDTH-1:0]                lb_in, lb_out;
    logic [WIN_DIM-1:0][DATA_WIDTH-1:0]               col_new;
    logic [WIN_DIM-1:0][WIN_DIM-1:0][DATA_WIDTH-1:0]  win_q, win_d;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic          win_ok;
    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LB; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_in[gi] = in_data;
            end else begin : g_tail
                assign lb_in[gi] = lb_out[gi-1];
            end
            window_buffer5x5_line_buffer #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (IMG_WIDTH)
            ) u_lb (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (in_valid),
                .din_i (lb_in[gi]),
                .dout_o(lb_out[gi])
            );
            // Deeper line buffers hold older rows, i.e. rows nearer the top.
            assign col_new[NUM_LB-1-gi] = lb_out[gi];
        end
    endgenerate
    assign col_new[WIN_DIM-1] = in_data;

    // A qualified in_sof pins the incoming pixel to (0,0) whatever the counters say.
    assign cur_row = (in_valid && in_sof) ? '0 : row_q;
    assign cur_col = (in_valid && in_sof) ? '0 : col_q;
    assign win_ok  = in_valid && (cur_row >= RW'(CTR_MIN)) && (cur_col >= CW'(CTR_MIN));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (in_valid) begin
            if (cur_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM - 1; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][WIN_DIM-1] = col_new[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            out_valid_q <= win_ok;
            if (win_ok) begin
                out_row_q <= cur_row - RW'(CTR_OFS);
                out_col_q <= cur_col - CW'(CTR_OFS);
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_row      = out_row_q;
    assign out_col      = out_col_q;
    // Row-major packed array already matches the k = r*5+c element layout.
    assign pack_wBuffer = WINDOW_BITS'(win_q);
endmodule
